// File: rtl/vector_regfile_stream.sv
// vector_regfile_stream: vector register file with two read ports, masked parallel write and element-serial stream fill
// Define VRF_BYPASS_EN to forward writes committing on the coming edge onto the read ports.
module vector_regfile_stream #(
  parameter int NUM_VREGS = 16,
  parameter int VLEN = 5,
  parameter int DATA_W = 32,
  localparam int IDX_W = $clog2(NUM_VREGS),
  localparam int CNT_W = $clog2(VLEN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IDX_W-1:0]       ra1,
  input  logic [IDX_W-1:0]       ra2,
  output logic [VLEN*DATA_W-1:0] rd1,
  output logic [VLEN*DATA_W-1:0] rd2,
  input  logic                   we,
  input  logic [IDX_W-1:0]       wa,
  input  logic [VLEN-1:0]        wmask,
  input  logic [VLEN*DATA_W-1:0] wd,
  input  logic                   s_start,
  input  logic [IDX_W-1:0]       s_vd,
  input  logic                   s_valid,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   s_ready,
  output logic                   s_done,
  output logic [NUM_VREGS-1:0]   busy_mask
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] vd_q, vd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic [DATA_W-1:0] vreg_q [NUM_VREGS][VLEN];
  logic [DATA_W-1:0] vreg_d [NUM_VREGS][VLEN];
  logic s_acc, s_last;
  assign s_acc = (state_q == STREAM) && s_valid;
  assign s_last = cnt_q == CNT_W'(VLEN - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vd_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      for (int r = 0; r < NUM_VREGS; r++)
        for (int i = 0; i < VLEN; i++)
          vreg_q[r][i] <= '0;
    end else begin
      state_q <= state_d;
      vd_q <= vd_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      vreg_q <= vreg_d;
    end
  end
  always_comb begin
    state_d = state_q;
    vd_d = vd_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    if (state_q == IDLE && s_start) begin
      state_d = STREAM;
      vd_d = s_vd;
      cnt_d = '0;
    end else if (s_acc) begin
      state_d = s_last ? IDLE : STREAM;
      cnt_d = s_last ? '0 : cnt_q + 1'b1;
      done_d = s_last;
    end
  end
  always_comb begin
    s_ready = state_q == STREAM;
    s_done = done_q;
    busy_mask = s_ready ? NUM_VREGS'(1) << vd_q : '0;
  end
  // Parallel write is applied last so it wins an element collision with the stream.
  always_comb begin
    vreg_d = vreg_q;
    if (s_acc) vreg_d[vd_q][cnt_q] = s_data;
    if (we)
      for (int i = 0; i < VLEN; i++)
        if (wmask[i]) vreg_d[wa][i] = wd[i*DATA_W +: DATA_W];
  end
  always_comb begin
    for (int i = 0; i < VLEN; i++) begin
      rd1[i*DATA_W +: DATA_W] = vreg_q[ra1][i];
      rd2[i*DATA_W +: DATA_W] = vreg_q[ra2][i];
`ifdef VRF_BYPASS_EN
      if (s_acc && vd_q == ra1 && cnt_q == CNT_W'(i)) rd1[i*DATA_W +: DATA_W] = s_data;
      if (s_acc && vd_q == ra2 && cnt_q == CNT_W'(i)) rd2[i*DATA_W +: DATA_W] = s_data;
      if (we && wa == ra1 && wmask[i]) rd1[i*DATA_W +: DATA_W] = wd[i*DATA_W +: DATA_W];
      if (we && wa == ra2 && wmask[i]) rd2[i*DATA_W +: DATA_W] = wd[i*DATA_W +: DATA_W];
`endif
    end
  end
endmodule

// File: tb/tb_vector_regfile_stream.sv
// tb_vector_regfile_stream: directed checks of reset, masked write, stream fill, collision, mid-fill reset, bypass
module tb_vector_regfile_stream;
  logic clk = 0, reset = 0;
  logic [3:0] ra1 = 0, ra2 = 0, wa = 0, s_vd = 0;
  logic [159:0] rd1, rd2, wd = 0;
  logic we = 0, s_start = 0, s_valid = 0, s_ready, s_done;
  logic [4:0] wmask = 0;
  logic [31:0] s_data = 0;
  logic [15:0] busy_mask;
  int n_checks = 0, n_err = 0;
  vector_regfile_stream dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wmask(wmask), .wd(wd), .s_start(s_start), .s_vd(s_vd),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .s_done(s_done),
    .busy_mask(busy_mask)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [159:0] pk(input logic [31:0] e4, e3, e2, e1, e0);
    return {e4, e3, e2, e1, e0};
  endfunction
  task automatic fill(input logic [3:0] vd, input logic [31:0] base);
    s_start = 1; s_vd = vd;
    step();
    s_start = 0;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1; s_data = base + k;
      step();
    end
    s_valid = 0;
    #1;
  endtask
  initial begin
    #3 reset = 1;
    #1;
    for (int r = 0; r < 16; r++) begin
      ra1 = r[3:0]; ra2 = 4'(15 - r);
      #1;
      check("reset_rd1", rd1, '0);
      check("reset_rd2", rd2, '0);
    end
    check("reset_ready", {159'd0, s_ready}, '0);
    check("reset_done", {159'd0, s_done}, '0);
    check("reset_busy", {144'd0, busy_mask}, '0);
    #1 reset = 0;
    step();
    we = 1; wa = 3; wmask = 5'b10101; wd = pk(15, 14, 13, 12, 11);
    step();
    we = 0; ra1 = 3;
    #1 check("masked_write", rd1, pk(15, 0, 13, 0, 11));
    s_start = 1; s_vd = 7;
    step();
    s_start = 0; ra1 = 7;
    #1 check("stream_ready", {159'd0, s_ready}, 1);
    check("stream_busy", {144'd0, busy_mask}, 160'h80);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) repeat (2) begin
        s_valid = 0;
        step();
        check("stall_busy", {144'd0, busy_mask}, 160'h80);
        check("stall_done", {159'd0, s_done}, 0);
        check("stall_partial", rd1, pk(0, 0, 0, 32'hA1, 32'hA0));
      end
      s_valid = 1; s_data = 32'hA0 + k;
      step();
      if (k < 4) check("beat_done", {159'd0, s_done}, 0);
      if (k < 4) check("beat_busy", {144'd0, busy_mask}, 160'h80);
    end
    s_valid = 0;
    #1 check("fill_done", {159'd0, s_done}, 1);
    check("fill_busy_clr", {144'd0, busy_mask}, 0);
    check("fill_ready_clr", {159'd0, s_ready}, 0);
    check("fill_data", rd1, pk(32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0));
    step();
    check("done_one_cycle", {159'd0, s_done}, 0);
    s_start = 1; s_vd = 2;
    step();
    s_start = 0;
    s_valid = 1; s_data = 32'h20;
    step();
    s_data = 32'h21; we = 1; wa = 2; wmask = 5'b00011; wd = {5{32'h55}};
    step();
    we = 0;
    for (int k = 2; k < 5; k++) begin
      s_data = 32'h20 + k;
      step();
    end
    s_valid = 0; ra2 = 2;
    #1 check("collision", rd2, pk(32'h24, 32'h23, 32'h22, 32'h55, 32'h55));
    check("collision_done", {159'd0, s_done}, 1);
    step();
    s_start = 1; s_vd = 4;
    step();
    s_start = 0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1; s_data = 32'h40 + k;
      step();
    end
    s_valid = 0; ra1 = 4;
    #1 check("pre_reset_partial", rd1, pk(0, 0, 32'h42, 32'h41, 32'h40));
    #1 reset = 1;
    #1 check("midreset_r4", rd1, '0);
    check("midreset_r7", rd2 | '0, rd2);
    ra2 = 7;
    #1 check("midreset_r7", rd2, '0);
    check("midreset_ready", {159'd0, s_ready}, 0);
    check("midreset_busy", {144'd0, busy_mask}, 0);
    #1 reset = 0;
    step();
    check("midreset_no_done", {159'd0, s_done}, 0);
    check("midreset_idle", {159'd0, s_ready}, 0);
    fill(4, 32'h50);
    check("refill_done", {159'd0, s_done}, 1);
    check("refill_data", rd1, pk(32'h54, 32'h53, 32'h52, 32'h51, 32'h50));
    step();
    we = 1; wa = 6; wmask = 5'b11111; wd = {5{32'h11}};
    step();
    ra1 = 6; ra2 = 4; wd = {5{32'h77}};
    #1;
`ifdef VRF_BYPASS_EN
    check("bypass_same_cycle", rd1, {5{32'h77}});
`else
    check("no_bypass_old", rd1, {5{32'h11}});
`endif
    check("bypass_other_port", rd2, pk(32'h54, 32'h53, 32'h52, 32'h51, 32'h50));
    step();
    we = 1; wmask = 5'b00000; wd = {5{32'h99}};
    #1 check("bypass_next_cycle", rd1, {5{32'h77}});
    step();
    we = 0;
    #1 check("zero_mask_noop", rd1, {5{32'h77}});
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
